sram_port_arbiter: RTL and testbench
====================================

SRAM_PORT_ARBITER -- requirements
Module: sram_port_arbiter

Interface
REQ-001 Parameter NumReq, default 4, number of requesters sharing one single-port SRAM; SHALL be >= 1.
REQ-002 Parameter NumWords, default 1024, SRAM depth in words.
REQ-003 Parameter DataWidth, default 32, data width in bits.
REQ-004 Parameter ByteWidth, default 8, byte width in bits.
REQ-005 Parameter Latency, default 1, SRAM read latency in cycles; SHALL be >= 1.
REQ-006 Derived AddrWidth = (NumWords > 1) ? clog2(NumWords) : 1; BeWidth = ceil(DataWidth/ByteWidth); IdxWidth = (NumReq > 1) ? clog2(NumReq) : 1; these SHALL NOT be overridden.
REQ-007 Port clk_i  in  1  single clock; all state on rising edge.
REQ-008 Port rst_ni  in  1  reset, synchronous, active-low.
REQ-009 Port req_valid_i  in  NumReq  per-requester request valid.
REQ-010 Port req_ready_o  out  NumReq  per-requester grant; request accepted when valid and ready are both high.
REQ-011 Port req_we_i  in  NumReq  write enable per requester.
REQ-012 Port req_addr_i  in  NumReq x AddrWidth  word address per requester.
REQ-013 Port req_wdata_i  in  NumReq x DataWidth  write data per requester.
REQ-014 Port req_be_i  in  NumReq x BeWidth  byte enables per requester.
REQ-015 Port rsp_valid_o  out  NumReq  one-cycle response strobe per requester.
REQ-016 Port rsp_rdata_o  out  DataWidth  shared read data; qualified by rsp_valid_o.
REQ-017 Ports sram_req_o (1), sram_we_o (1), sram_addr_o (AddrWidth), sram_wdata_o (DataWidth), sram_be_o (BeWidth)  out  one SRAM port.
REQ-018 Port sram_rdata_i  in  DataWidth  SRAM read data, valid Latency cycles after sram_req_o.

Function
REQ-019 Arbitration SHALL be round-robin and combinational: the winner is the first asserted req_valid_i at or after index rr_q, wrapping modulo NumReq.
REQ-020 req_ready_o SHALL be one-hot for the winner and all-zero when no req_valid_i is asserted; there is no backpressure from the SRAM, so a winner is granted every cycle.
REQ-021 sram_req_o SHALL equal OR of req_valid_i; sram_we_o, sram_addr_o, sram_wdata_o, sram_be_o SHALL mux the winner's fields; when idle these outputs SHALL be 0.
REQ-022 sram_be_o SHALL be the winner's req_be_i gated by req_we_i (all-zero for reads).
REQ-023 On a grant to index i, rr_q SHALL update to (i+1) mod NumReq on the next edge; with no grant, rr_q SHALL hold.
REQ-024 Each grant SHALL push {valid=1, idx=i} into a Latency-deep shift pipeline; non-grant cycles SHALL push valid=0.
REQ-025 When the pipeline output is valid, rsp_valid_o[idx] SHALL pulse for exactly one cycle, exactly Latency cycles after the grant cycle, for both reads and writes (writes act as acknowledgement).
REQ-026 rsp_rdata_o SHALL pass sram_rdata_i combinationally; content on write responses is don't-care.
REQ-027 Back-to-back grants SHALL produce back-to-back responses in grant order; throughput SHALL be one request per cycle.
REQ-028 With NumReq = 1, req_ready_o SHALL equal req_valid_i and rr_q SHALL be constant 0.
REQ-029 Responses SHALL NOT be stalled; requesters always accept rsp_valid_o.

Reset
REQ-030 While rst_ni is low at a rising edge: rr_q <= 0 and all pipeline valid bits <= 0; rsp_valid_o SHALL be all-zero from the following cycle.
REQ-031 Reset asserted mid-operation SHALL drop all in-flight responses; none SHALL be emitted after reset deasserts.
REQ-032 While rst_ni is low, req_ready_o and sram_req_o SHALL be forced to 0.

Verification
REQ-033 NumReq=4, Latency=1, only req 2 reads addr 0x10 holding 0xDEADBEEF -> ready[2]=1 same cycle; next cycle rsp_valid_o=4'b0100, rsp_rdata_o=0xDEADBEEF.
REQ-034 All 4 requesters valid continuously for 8 cycles after reset -> grants 0,1,2,3,0,1,2,3; each requester gets exactly 2 responses.
REQ-035 Req 1 writes 0xA5A5A5A5 with be=4'b0011 to addr 5, then reads addr 5 (prior content 0) -> read data 0x0000A5A5; sram_be_o=0 during the read.
REQ-036 Latency=3, grants to req 0,3,1 in consecutive cycles -> rsp_valid_o pulses 0001,1000,0010 on cycles +3,+4,+5.
REQ-037 Latency=2, grant at cycle t, rst_ni low at cycle t+1 for one cycle -> no rsp_valid_o pulse; next grant after reset goes to lowest valid index from 0.
REQ-038 Idle with no req_valid_i for 10 cycles -> sram_req_o=0, rr_q unchanged, rsp_valid_o=0.

Source files
------------

// File: rtl/sram_port_arbiter.sv
// Round-robin arbiter sharing one single-port SRAM among NumReq requesters; grant is combinational.
// Responses come back Latency cycles after grant, in grant order, one per cycle, never stalled.
module sram_port_arbiter #(
  parameter int NumReq    = 4,
  parameter int NumWords  = 1024,
  parameter int DataWidth = 32,
  parameter int ByteWidth = 8,
  parameter int Latency   = 1,
  localparam int AddrWidth = (NumWords > 1) ? $clog2(NumWords) : 1,
  localparam int BeWidth   = (DataWidth + ByteWidth - 1) / ByteWidth,
  localparam int IdxWidth  = (NumReq > 1) ? $clog2(NumReq) : 1
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic [NumReq-1:0]             req_valid_i,
  output logic [NumReq-1:0]             req_ready_o,
  input  logic [NumReq-1:0]             req_we_i,
  input  logic [NumReq*AddrWidth-1:0]   req_addr_i,
  input  logic [NumReq*DataWidth-1:0]   req_wdata_i,
  input  logic [NumReq*BeWidth-1:0]     req_be_i,
  output logic [NumReq-1:0]             rsp_valid_o,
  output logic [DataWidth-1:0]          rsp_rdata_o,
  output logic                          sram_req_o,
  output logic                          sram_we_o,
  output logic [AddrWidth-1:0]          sram_addr_o,
  output logic [DataWidth-1:0]          sram_wdata_o,
  output logic [BeWidth-1:0]            sram_be_o,
  input  logic [DataWidth-1:0]          sram_rdata_i
);

  logic [IdxWidth-1:0] rr_q;
  logic [IdxWidth-1:0] win_idx;
  logic                win_vld;
  logic                grant;
  logic [Latency-1:0]  pipe_vld;
  logic [IdxWidth-1:0] pipe_idx [Latency];

  // Scan from the round-robin pointer, wrapping at NumReq (which need not be a power of two).
  always_comb begin
    int c;
    win_vld = 1'b0;
    win_idx = '0;
    for (int k = 0; k < NumReq; k++) begin
      c = int'(rr_q) + k;
      if (c >= NumReq) c = c - NumReq;
      if (!win_vld && req_valid_i[IdxWidth'(c)]) begin
        win_vld = 1'b1;
        win_idx = IdxWidth'(c);
      end
    end
  end

  assign grant      = rst_ni & win_vld;
  assign sram_req_o = grant;

  always_comb begin
    req_ready_o  = '0;
    sram_we_o    = 1'b0;
    sram_addr_o  = '0;
    sram_wdata_o = '0;
    sram_be_o    = '0;
    if (grant) begin
      req_ready_o[win_idx] = 1'b1;
      sram_we_o    = req_we_i[win_idx];
      sram_addr_o  = req_addr_i[win_idx*AddrWidth +: AddrWidth];
      sram_wdata_o = req_wdata_i[win_idx*DataWidth +: DataWidth];
      sram_be_o    = req_we_i[win_idx] ? req_be_i[win_idx*BeWidth +: BeWidth] : '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rr_q <= '0;
    end else if (grant) begin
      rr_q <= (win_idx == IdxWidth'(NumReq - 1)) ? '0 : win_idx + 1'b1;
    end
  end

  // Only the valid bits need clearing; a stale index is harmless while its valid bit is low.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      pipe_vld <= '0;
    end else begin
      pipe_vld[0] <= grant;
      for (int i = 1; i < Latency; i++) pipe_vld[i] <= pipe_vld[i-1];
    end
  end

  always_ff @(posedge clk_i) begin
    pipe_idx[0] <= win_idx;
    for (int i = 1; i < Latency; i++) pipe_idx[i] <= pipe_idx[i-1];
  end

  always_comb begin
    rsp_valid_o = '0;
    if (pipe_vld[Latency-1]) rsp_valid_o[pipe_idx[Latency-1]] = 1'b1;
  end

  assign rsp_rdata_o = sram_rdata_i;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Three arbiters (Latency 1, 2, 3) share one stimulus stream; each drives its own SRAM model.
module tb_sram_port_arbiter;

  logic clk;
  logic rst_n;
  logic [3:0]  valid, we;
  logic [5:0]  addr  [4];
  logic [31:0] wdata [4];
  logic [3:0]  be    [4];
  logic [23:0]  addr_f;
  logic [127:0] wdata_f;
  logic [15:0]  be_f;

  assign addr_f  = {addr[3], addr[2], addr[1], addr[0]};
  assign wdata_f = {wdata[3], wdata[2], wdata[1], wdata[0]};
  assign be_f    = {be[3], be[2], be[1], be[0]};

  logic [2:0][3:0]  ready_a, rsp_a, sbe_a;
  logic [2:0]       sreq_a, swe_a;
  logic [2:0][5:0]  saddr_a;
  logic [2:0][31:0] swdata_a, srdata_a, rdata_a;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : gen_dut
    localparam int L = g + 1;
    logic [31:0] mem  [64];
    logic [31:0] pipe [L];

    always @(posedge clk) begin
      if (sreq_a[g]) begin
        if (swe_a[g]) begin
          for (int b = 0; b < 4; b++)
            if (sbe_a[g][b]) mem[saddr_a[g]][b*8 +: 8] = swdata_a[g][b*8 +: 8];
        end else begin
          pipe[0] <= mem[saddr_a[g]];
        end
      end
      for (int i = 1; i < L; i++) pipe[i] <= pipe[i-1];
    end

    initial begin
      for (int i = 0; i < 64; i++) mem[i] = 32'h0;
      mem[16] = 32'hDEADBEEF;
    end

    assign srdata_a[g] = pipe[L-1];

    sram_port_arbiter #(
      .NumReq(4), .NumWords(64), .DataWidth(32), .ByteWidth(8), .Latency(L)
    ) u_dut (
      .clk_i       (clk),
      .rst_ni      (rst_n),
      .req_valid_i (valid),
      .req_ready_o (ready_a[g]),
      .req_we_i    (we),
      .req_addr_i  (addr_f),
      .req_wdata_i (wdata_f),
      .req_be_i    (be_f),
      .rsp_valid_o (rsp_a[g]),
      .rsp_rdata_o (rdata_a[g]),
      .sram_req_o  (sreq_a[g]),
      .sram_we_o   (swe_a[g]),
      .sram_addr_o (saddr_a[g]),
      .sram_wdata_o(swdata_a[g]),
      .sram_be_o   (sbe_a[g]),
      .sram_rdata_i(srdata_a[g])
    );
  end

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;
  int rr    = 0;
  int rsp_cnt [4];
  logic [31:0] mmem [64];
  bit          h_vld  [4096];
  int          h_idx  [4096];
  bit          h_we   [4096];
  logic [31:0] h_data [4096];
  bit          h_rst  [4096];

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
    end
  endtask

  // Reference: arbitration from the round-robin rule, responses from a per-cycle grant history.
  task automatic evaluate();
    int w;
    int t;
    bit gv, alive, rd;
    logic [3:0]  er, ersp;
    logic [31:0] ed;
    w  = 0;
    gv = rst_n && (valid != 4'b0);
    if (gv) begin
      for (int k = 3; k >= 0; k--)
        if (valid[(rr + k) % 4]) w = (rr + k) % 4;
    end
    er = gv ? 4'(1 << w) : 4'b0;
    for (int g = 0; g < 3; g++) begin
      check_val($sformatf("ready_L%0d", g+1), 64'(ready_a[g]), 64'(er));
      check_val($sformatf("sram_req_L%0d", g+1), 64'(sreq_a[g]), 64'(gv));
      check_val($sformatf("sram_we_L%0d", g+1), 64'(swe_a[g]), gv ? 64'(we[w]) : 64'd0);
      check_val($sformatf("sram_addr_L%0d", g+1), 64'(saddr_a[g]), gv ? 64'(addr[w]) : 64'd0);
      check_val($sformatf("sram_wdata_L%0d", g+1), 64'(swdata_a[g]), gv ? 64'(wdata[w]) : 64'd0);
      check_val($sformatf("sram_be_L%0d", g+1), 64'(sbe_a[g]), (gv && we[w]) ? 64'(be[w]) : 64'd0);
      t = cyc - (g + 1);
      ersp = 4'b0;
      rd = 1'b0;
      ed = 32'h0;
      if (t >= 0 && h_vld[t]) begin
        alive = 1'b1;
        for (int c2 = t + 1; c2 < cyc; c2++) if (h_rst[c2]) alive = 1'b0;
        if (alive) begin
          ersp = 4'(1 << h_idx[t]);
          rd = !h_we[t];
          ed = h_data[t];
        end
      end
      check_val($sformatf("rsp_valid_L%0d", g+1), 64'(rsp_a[g]), 64'(ersp));
      if (rd) check_val($sformatf("rsp_rdata_L%0d", g+1), 64'(rdata_a[g]), 64'(ed));
    end
    for (int i = 0; i < 4; i++) rsp_cnt[i] += int'(rsp_a[0][i]);
    h_vld[cyc]  = gv;
    h_idx[cyc]  = w;
    h_we[cyc]   = gv && we[w];
    h_data[cyc] = mmem[addr[w]];
    h_rst[cyc]  = !rst_n;
    if (!rst_n) rr = 0;
    else if (gv) rr = (w + 1) % 4;
    if (gv && we[w])
      for (int b = 0; b < 4; b++)
        if (be[w][b]) mmem[addr[w]][b*8 +: 8] = wdata[w][b*8 +: 8];
  endtask

  task automatic tick();
    @(negedge clk);
    evaluate();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle();
    valid = 4'b0;
    we    = 4'b0;
    for (int i = 0; i < 4; i++) begin
      addr[i]  = 6'h0;
      wdata[i] = 32'h0;
      be[i]    = 4'h0;
    end
  endtask

  task automatic set_req(input int i, input bit w, input logic [5:0] a,
                         input logic [31:0] d, input logic [3:0] b);
    valid[i] = 1'b1;
    we[i]    = w;
    addr[i]  = a;
    wdata[i] = d;
    be[i]    = b;
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mmem[i] = 32'h0;
    mmem[16] = 32'hDEADBEEF;
    for (int i = 0; i < 4; i++) rsp_cnt[i] = 0;
    idle();
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    tick();
    tick();
    rst_n = 1'b1;

    // single read from requester 2
    set_req(2, 1'b0, 6'h10, 32'h0, 4'h0);
    tick();
    idle();
    tick();

    // idle stretch
    repeat (10) tick();

    // all requesters continuously valid after a reset
    for (int i = 0; i < 4; i++) rsp_cnt[i] = 0;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) set_req(i, 1'b0, 6'(i), 32'h0, 4'h0);
    repeat (8) tick();
    idle();
    repeat (3) tick();
    for (int i = 0; i < 4; i++) check_val($sformatf("rsp_count_%0d", i), 64'(rsp_cnt[i]), 64'd2);

    // partial-byte write then read-back
    set_req(1, 1'b1, 6'd5, 32'hA5A5A5A5, 4'b0011);
    tick();
    idle();
    set_req(1, 1'b0, 6'd5, 32'h0, 4'hF);
    tick();
    idle();
    repeat (3) tick();

    // consecutive grants to 0, 3, 1
    set_req(0, 1'b0, 6'd16, 32'h0, 4'h0);
    tick();
    idle();
    set_req(3, 1'b0, 6'd5, 32'h0, 4'h0);
    tick();
    idle();
    set_req(1, 1'b1, 6'd9, 32'h12345678, 4'hF);
    tick();
    idle();
    repeat (4) tick();

    // grant followed by one reset cycle with requests pending
    set_req(2, 1'b0, 6'd5, 32'h0, 4'h0);
    tick();
    valid = 4'b1111;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    idle();
    set_req(1, 1'b0, 6'd16, 32'h0, 4'h0);
    set_req(3, 1'b0, 6'd5, 32'h0, 4'h0);
    tick();
    idle();
    repeat (4) tick();

    // randomized traffic with occasional resets
    for (int n = 0; n < 800; n++) begin
      idle();
      rst_n = ($urandom_range(0, 49) != 0);
      for (int i = 0; i < 4; i++)
        if ($urandom_range(0, 2) != 0)
          set_req(i, 1'($urandom_range(0, 1)), 6'($urandom_range(0, 63)),
                  $urandom, 4'($urandom_range(0, 15)));
      tick();
    end
    idle();
    rst_n = 1'b1;
    repeat (5) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
